dmx_serial_rx: RTL and testbench

Parametrised async serial receiver, successor to the fixed 8N1 DMX byte receiver.
- Configurable data bits, parity and stop bits.
- Internal input synchroniser and false-start rejection.
- Per-byte framing/parity error flags.
- DMX BREAK detection by measured low time.
- Sits between the DMX line transceiver and the DMX frame/slot decoder.

---
 rtl/dmx_serial_rx_if.sv | 43 ++++
 rtl/dmx_serial_rx.sv | 273 +++++++++++++++++++++++++++
 tb/tb_dmx_serial_rx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmx_serial_rx_if.sv
// dmx_serial_rx_if: signal bundle between the DMX line side and the receiver.
//
// Handshake: there is no back-pressure. rx_valid, frame_err, parity_err and
// break_det are single-cycle pulses, at most one per character. rx_data is
// only meaningful in the cycle rx_valid is high and is held until the next
// good character. The consumer must sample every cycle.
//
// slave  : the receiver (dmx_serial_rx)
// master : whatever drives the line and consumes the characters
interface dmx_serial_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_en;
    logic                 rx_in;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 break_det;
    logic                 busy;

    modport slave (
        input  rx_en,
        input  rx_in,
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output break_det,
        output busy
    );

    modport master (
        output rx_en,
        output rx_in,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  break_det,
        input  busy
    );
endinterface

// File: rtl/dmx_serial_rx.sv
// dmx_serial_rx: parametrised asynchronous serial receiver for a DMX line.
//
// Data bits, parity mode and stop-bit count are parameters. The line is
// synchronised internally, false starts are rejected at the start-bit sample
// point, and every character ends in exactly one of: rx_valid, parity_err,
// frame_err or break_det. A BREAK is a low time of at least BREAK_BITS bit
// times and is reported when the line returns high.
//
// Optional build macro RX_MAJORITY_VOTE_EN: each bit is decided by a 2-of-3
// vote of samples at sample point -BIT_TIME/8, at the sample point and at
// +BIT_TIME/8; every decision then lands BIT_TIME/8 cycles later.
//
// dbg_state exposes the FSM state encoding for observation.
module dmx_serial_rx #(
    parameter int CLK_FREQ    = 20_000_000,
    parameter int BAUD_RATE   = 250_000,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 2,
    parameter int BREAK_BITS  = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmx_serial_rx_if.slave       bus,
    output logic [2:0]           dbg_state
);

    localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT = BIT_TIME / 2;
    localparam int TW       = $clog2(BIT_TIME + 1);
    localparam int LOW_MAX  = BREAK_BITS * BIT_TIME;
    localparam int LW       = $clog2(LOW_MAX + 1);

`ifdef RX_MAJORITY_VOTE_EN
    localparam int EIGHTH_BIT = BIT_TIME / 8;
    localparam int VOTE_LAT   = EIGHTH_BIT;
`else
    localparam int VOTE_LAT   = 0;
`endif

    // Bit-timer value at which a bit decision is taken. The first decision
    // (start bit) comes half a bit after t0, later ones every full bit.
    localparam logic [TW-1:0] START_LAST = TW'(HALF_BIT + VOTE_LAT - 1);
    localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_TIME - 1);
    localparam logic [LW-1:0] LOW_SAT    = LW'(LOW_MAX);
    localparam logic [3:0]    LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP  = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD    = (PARITY_MODE == 2);

    // Reject illegal configurations at elaboration time.
    if (BIT_TIME < 8) begin : g_bad_bit_time
        $error("dmx_serial_rx: CLK_FREQ/BAUD_RATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("dmx_serial_rx: DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("dmx_serial_rx: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("dmx_serial_rx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t               state;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 fall;
    logic [TW-1:0]        bit_cnt;
    logic [TW-1:0]        target;
    logic                 tick;
    logic                 bit_val;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_acc;
    logic                 parity_ok;
    logic [LW-1:0]        low_cnt;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 break_det_q;

    // Two-flop synchroniser plus previous-value flop for falling-edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], bus.rx_in};
            rx_prev <= sync_q[1];
        end
    end

    assign rx_s = sync_q[1];
    assign fall = rx_prev & ~rx_s;

    // Low-time counter: counts consecutive low cycles, saturating at the
    // BREAK threshold, cleared by any high cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            low_cnt <= '0;
        end else if (rx_s) begin
            low_cnt <= '0;
        end else if (low_cnt != LOW_SAT) begin
            low_cnt <= low_cnt + LW'(1);
        end
    end

    assign target = (state == START) ? START_LAST : BIT_LAST;
    assign tick   = (bit_cnt == target);

`ifdef RX_MAJORITY_VOTE_EN
    logic vote_a;
    logic vote_b;

    // Capture the two early votes; the third vote is rx_s at the decision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else begin
            if (bit_cnt == target - TW'(2 * EIGHTH_BIT)) begin
                vote_a <= rx_s;
            end
            if (bit_cnt == target - TW'(EIGHTH_BIT)) begin
                vote_b <= rx_s;
            end
        end
    end

    assign bit_val = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // Receive FSM: bit timing, shifting, parity/stop checks and result pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            shift_q      <= '0;
            par_acc      <= 1'b0;
            parity_ok    <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_det_q  <= 1'b0;
        end else begin
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_det_q  <= 1'b0;

            if (!bus.rx_en) begin
                // Disabled: abandon any character silently.
                state   <= IDLE;
                bit_cnt <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fall) begin
                            state     <= START;
                            bit_cnt   <= '0;
                            bit_idx   <= '0;
                            par_acc   <= 1'b0;
                            parity_ok <= 1'b1;
                        end
                    end

                    START: begin
                        if (tick) begin
                            bit_cnt <= '0;
                            // A high start sample is a glitch, not a character.
                            state   <= bit_val ? IDLE : DATA;
                        end else begin
                            bit_cnt <= bit_cnt + TW'(1);
                        end
                    end

                    DATA: begin
                        if (tick) begin
                            bit_cnt <= '0;
                            shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                            par_acc <= par_acc ^ bit_val;
                            if (bit_idx == LAST_DATA) begin
                                bit_idx <= '0;
                                state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + TW'(1);
                        end
                    end

                    PARITY: begin
                        if (tick) begin
                            bit_cnt   <= '0;
                            // Only remembered here; reported after the stops.
                            parity_ok <= ((par_acc ^ bit_val) == PAR_ODD);
                            state     <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + TW'(1);
                        end
                    end

                    STOP: begin
                        if (tick) begin
                            bit_cnt <= '0;
                            if (!bit_val) begin
                                // Framing problem or BREAK; decided on return high.
                                state   <= WAIT_HIGH;
                                bit_idx <= '0;
                            end else if (bit_idx == LAST_STOP) begin
                                state   <= IDLE;
                                bit_idx <= '0;
                                if (parity_ok) begin
                                    rx_valid_q <= 1'b1;
                                    rx_data_q  <= shift_q;
                                end else begin
                                    parity_err_q <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + TW'(1);
                        end
                    end

                    WAIT_HIGH: begin
                        if (rx_s) begin
                            state <= IDLE;
                            // low_cnt still holds the length of the low period.
                            if (low_cnt == LOW_SAT) begin
                                break_det_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.break_det  = break_det_q;
    assign bus.busy       = (state != IDLE);
    assign dbg_state      = state;

endmodule

// File: tb/tb_dmx_serial_rx.sv
// tb_dmx_serial_rx: directed bench for dmx_serial_rx.
// Instance 0: defaults (8 data, no parity, 2 stops, BIT_TIME 80).
// Instance 1: 7 data bits, even parity, 2 stops.
// Every result pulse is checked against an expected-event queue.
module tb_dmx_serial_rx;

  localparam int BT = 80;
`ifdef RX_MAJORITY_VOTE_EN
  localparam int LAT = BT / 8;
`else
  localparam int LAT = 0;
`endif

  localparam logic [2:0] K_VALID  = 3'd1;
  localparam logic [2:0] K_FRAME  = 3'd2;
  localparam logic [2:0] K_PARITY = 3'd3;
  localparam logic [2:0] K_BREAK  = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] dbg0;
  logic [2:0] dbg1;

  dmx_serial_rx_if #(.DATA_BITS(8)) if0 ();
  dmx_serial_rx_if #(.DATA_BITS(7)) if1 ();

  dmx_serial_rx u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (if0.slave),
    .dbg_state (dbg0)
  );

  dmx_serial_rx #(
    .DATA_BITS   (7),
    .PARITY_MODE (1)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (if1.slave),
    .dbg_state (dbg1)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] enc(input logic v, input logic f, input logic p,
                                      input logic b, input logic [8:0] d);
    case ({v, f, p, b})
      4'b1000: return {K_VALID, d};
      4'b0100: return {K_FRAME, 9'd0};
      4'b0010: return {K_PARITY, 9'd0};
      4'b0001: return {K_BREAK, 9'd0};
      default: return {3'd7, 9'd0};
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];
  logic [11:0] obs0;
  logic [11:0] obs1;
  int valid_cyc0 = -1;
  int break_cyc0 = -1;
  int frame_cyc0 = -1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (if0.rx_valid | if0.frame_err | if0.parity_err | if0.break_det) begin
        obs0 = enc(if0.rx_valid, if0.frame_err, if0.parity_err, if0.break_det,
                   {1'b0, if0.rx_data});
        if (if0.rx_valid)  valid_cyc0 = cyc;
        if (if0.break_det) break_cyc0 = cyc;
        if (if0.frame_err) frame_cyc0 = cyc;
        if (exp_q0.size() == 0) check("dut0 unexpected pulse", {20'd0, obs0}, 32'd0);
        else check("dut0 event", {20'd0, obs0}, {20'd0, exp_q0.pop_front()});
      end
      if (if1.rx_valid | if1.frame_err | if1.parity_err | if1.break_det) begin
        obs1 = enc(if1.rx_valid, if1.frame_err, if1.parity_err, if1.break_det,
                   {2'b0, if1.rx_data});
        if (exp_q1.size() == 0) check("dut1 unexpected pulse", {20'd0, obs1}, 32'd0);
        else check("dut1 event", {20'd0, obs1}, {20'd0, exp_q1.pop_front()});
      end
    end
  end

  // ---------------- drivers ----------------
  int busy_cnt0 = 0;

  task automatic drive(input int sel, input logic v, input int n);
    if (sel == 0) if0.rx_in = v;
    else          if1.rx_in = v;
    repeat (n) begin
      @(negedge clk);
      if (if0.busy === 1'b1) busy_cnt0++;
    end
  endtask

  task automatic send_char(input int sel, input logic [8:0] data, input int nbits,
                           input bit has_par, input logic par,
                           input logic s1, input logic s2);
    drive(sel, 1'b0, BT);
    for (int i = 0; i < nbits; i++) drive(sel, data[i], BT);
    if (has_par) drive(sel, par, BT);
    drive(sel, s1, BT);
    drive(sel, s2, BT);
  endtask

  task automatic gap(input int sel);
    drive(sel, 1'b1, 2 * BT);
  endtask

  // ---------------- directed sequence ----------------
  int d;
  int r;
  logic [8:0] tmp;
  logic p;

  initial begin
    rst_n     = 1'b0;
    if0.rx_en = 1'b1;
    if0.rx_in = 1'b1;
    if1.rx_en = 1'b1;
    if1.rx_in = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset rx_data0", {24'd0, if0.rx_data}, 32'd0);
    check("reset rx_valid0", {31'd0, if0.rx_valid}, 32'd0);
    check("reset frame_err0", {31'd0, if0.frame_err}, 32'd0);
    check("reset parity_err0", {31'd0, if0.parity_err}, 32'd0);
    check("reset break_det0", {31'd0, if0.break_det}, 32'd0);
    check("reset busy0", {31'd0, if0.busy}, 32'd0);
    check("reset state0", {29'd0, dbg0}, 32'd0);
    check("reset busy1", {31'd0, if1.busy}, 32'd0);
    rst_n = 1'b1;
    gap(0);

    // 0xA5, exact rx_valid timing and busy over the whole frame
    exp_q0.push_back({K_VALID, 9'h0A5});
    busy_cnt0 = 0;
    d = cyc;
    send_char(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    check("a5 valid cycle", valid_cyc0, d + 843 + LAT);
    check("a5 busy cycles", busy_cnt0, 840 + LAT);
    check("a5 rx_data", {24'd0, if0.rx_data}, 32'h0A5);
    gap(0);

    // 30-cycle glitch, then 0x3C
    busy_cnt0 = 0;
    drive(0, 1'b0, 30);
    drive(0, 1'b1, 200);
    check("glitch busy cycles", busy_cnt0, 40 + LAT);
    check("glitch state idle", {29'd0, dbg0}, 32'd0);
    exp_q0.push_back({K_VALID, 9'h03C});
    send_char(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    gap(0);

    // 0x55 with second stop bit low: frame error, data held
    exp_q0.push_back({K_FRAME, 9'd0});
    send_char(0, 9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    gap(0);
    check("frame err data held", {24'd0, if0.rx_data}, 32'h03C);

    // Back-to-back characters with no idle gap
    exp_q0.push_back({K_VALID, 9'h012});
    exp_q0.push_back({K_VALID, 9'h0EF});
    send_char(0, 9'h012, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    send_char(0, 9'h0EF, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    gap(0);
    check("b2b rx_data", {24'd0, if0.rx_data}, 32'h0EF);

    // BREAK 100 us (2000 cycles), MAB 12 us, slot 0x00
    exp_q0.push_back({K_BREAK, 9'd0});
    exp_q0.push_back({K_VALID, 9'h000});
    drive(0, 1'b0, 2000);
    r = cyc;
    drive(0, 1'b1, 240);
    check("break cycle", break_cyc0, r + 3);
    send_char(0, 9'h000, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    gap(0);
    check("post break rx_data", {24'd0, if0.rx_data}, 32'h000);

    // 40 us low: too short for BREAK, frame error only
    exp_q0.push_back({K_FRAME, 9'd0});
    drive(0, 1'b0, 800);
    r = cyc;
    drive(0, 1'b1, 240);
    check("short low frame cycle", frame_cyc0, r + 3);

    // rx_en dropped mid-data
    tmp = 9'h05A;
    drive(0, 1'b0, BT);
    for (int i = 0; i < 3; i++) drive(0, tmp[i], BT);
    if0.rx_en = 1'b0;
    @(negedge clk);
    check("en drop busy", {31'd0, if0.busy}, 32'd0);
    check("en drop state", {29'd0, dbg0}, 32'd0);
    drive(0, 1'b1, BT);
    // Enable while the line is already low must not start a frame
    drive(0, 1'b0, 20);
    if0.rx_en = 1'b1;
    drive(0, 1'b0, 100);
    check("en on low line idle", {31'd0, if0.busy}, 32'd0);
    gap(0);
    exp_q0.push_back({K_VALID, 9'h096});
    send_char(0, 9'h096, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    gap(0);
    check("after en drop rx_data", {24'd0, if0.rx_data}, 32'h096);

    // Reset mid-data
    tmp = 9'h03C;
    drive(0, 1'b0, BT);
    for (int i = 0; i < 4; i++) drive(0, tmp[i], BT);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid reset busy", {31'd0, if0.busy}, 32'd0);
    check("mid reset state", {29'd0, dbg0}, 32'd0);
    check("mid reset rx_data", {24'd0, if0.rx_data}, 32'd0);
    rst_n = 1'b1;
    gap(0);
    exp_q0.push_back({K_VALID, 9'h0C3});
    send_char(0, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    gap(0);
    check("after reset rx_data", {24'd0, if0.rx_data}, 32'h0C3);

    // Instance 1: 7E2, wrong parity then correct parity for 0x41
    p = ^(9'h041);
    exp_q1.push_back({K_PARITY, 9'd0});
    send_char(1, 9'h041, 7, 1'b1, ~p, 1'b1, 1'b1);
    gap(1);
    check("parity err data held", {25'd0, if1.rx_data}, 32'd0);
    exp_q1.push_back({K_VALID, 9'h041});
    send_char(1, 9'h041, 7, 1'b1, p, 1'b1, 1'b1);
    gap(1);
    check("parity ok rx_data", {25'd0, if1.rx_data}, 32'h41);
    p = ^(9'h07F);
    exp_q1.push_back({K_VALID, 9'h07F});
    send_char(1, 9'h07F, 7, 1'b1, p, 1'b1, 1'b1);
    gap(1);
    // Bad parity and bad stop: frame error wins
    exp_q1.push_back({K_FRAME, 9'd0});
    send_char(1, 9'h02A, 7, 1'b1, ~(^(9'h02A)), 1'b0, 1'b1);
    gap(1);
    check("priority data held", {25'd0, if1.rx_data}, 32'h7F);

    drive(0, 1'b1, 200);
    check("dut0 queue drained", exp_q0.size(), 32'd0);
    check("dut1 queue drained", exp_q1.size(), 32'd0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
